// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes,
// FSM state encoding, and the lane-enable and load-formatting helpers.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte-lane write enables for an aligned access; size 11 behaves as a word.
    function automatic logic [3:0] be_from_size(input logic [1:0] a, input logic [1:0] sz);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate sub-word store data so every enabled lane sees the right bytes.
    function automatic logic [31:0] store_align(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] a,
                                                input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-addressed data array built from four byte-lane arrays, with a
// byte write enable and a registered read port. Contents are never reset;
// only the read register is cleared.
module dm_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rd_reg;

            // Lane write, gated by its own byte enable.
            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            // Registered lane read; the read register clears on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_rd_reg <= 8'h00;
                end else if (re) begin
                    lane_rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/data_mem_stage.sv
// MEM-stage data memory: accepts an aligned load/store, holds the pipeline
// in stall for LATENCY+1 cycles, then presents the formatted load result
// for one DONE cycle so MEM/WB captures it as stall drops.
module data_mem_stage
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state_reg;
    logic [3:0]    cnt_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [1:0]    size_reg;
    logic          unsigned_reg;
    logic          is_write_reg;

    logic          req;
    logic          accept;
    logic          commit;
    logic          ram_we;
    logic          ram_re;
    logic [31:0]   rdata_q;
    logic          unused_addr_hi;

    // Address bits above the word index wrap away by design.
    assign unused_addr_hi = ^addr[31:AW+2];

    assign req      = mem_read | mem_write;
    assign misalign = req & (((size == SZ_HALF) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
    assign accept   = (state_reg == ST_IDLE) & req & ~misalign;

    // The access happens on the edge that ends the last WAIT cycle; reset
    // on that same edge aborts it.
    assign commit = (state_reg == ST_WAIT) && (cnt_reg == 4'd0) && !rst;
    assign ram_we = commit & is_write_reg;
    assign ram_re = commit & ~is_write_reg;

    // Stall must rise in the accepting cycle itself so the PC and pipeline
    // registers do not advance past the memory instruction.
    assign stall = accept | (state_reg == ST_WAIT);

    assign rd_data = ((state_reg == ST_DONE) && !is_write_reg)
                   ? load_format(rdata_q, addr_reg[1:0], size_reg, unsigned_reg)
                   : 32'h0;

    // Access sequencer: latch the request, count down the wait, then DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            is_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        addr_reg     <= addr[AW+1:0];
                        wdata_reg    <= wdata;
                        size_reg     <= size;
                        unsigned_reg <= unsigned_ld;
                        is_write_reg <= mem_write;
                        cnt_reg      <= 4'(LATENCY - 1);
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    dm_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .be    (be_from_size(addr_reg[1:0], size_reg)),
        .re    (ram_re),
        .addr  (addr_reg[AW+1:2]),
        .wdata (store_align(wdata_reg, size_reg)),
        .rdata (rdata_q)
    );

endmodule
